// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the E-stage forwarding / hazard unit.
//   - result-class codes carried by every scoreboard record
//   - TUSE_NONE: Tuse value meaning "this source is not read"
//   - sb_rec_t: one pipeline writer record {a3, res, tnew}
//   - fwd_sel_e: which source a forwarded operand was taken from
//   - rec_match / src_stall helpers used by the top and by fwd_sel
package fwd_pkg;

  localparam int SB_AW = 5;  // register-address width of a record
  localparam int SB_TW = 2;  // Tnew/Tuse width of a record

  localparam logic [2:0] RES_NW  = 3'd0;
  localparam logic [2:0] RES_ALU = 3'd1;
  localparam logic [2:0] RES_DM  = 3'd2;
  localparam logic [2:0] RES_PC  = 3'd3;
  localparam logic [2:0] RES_MD  = 3'd4;

  localparam logic [SB_TW-1:0] TUSE_NONE = '1;

  typedef struct packed {
    logic [SB_AW-1:0] a3;
    logic [2:0]       res;
    logic [SB_TW-1:0] tnew;
  } sb_rec_t;

  // All-zero record: a3=0 and res=NW, so it never matches anything.
  localparam sb_rec_t SB_BUBBLE = '0;

  typedef enum logic [2:0] {
    SEL_REG,
    SEL_E_PC8,
    SEL_M_AO,
    SEL_M_MD,
    SEL_M_PC8,
    SEL_W_WD
  } fwd_sel_e;

  // A record supplies register s only if it really writes a nonzero register.
  function automatic logic rec_match(input logic [SB_AW-1:0] s, input sb_rec_t r);
    return (s != '0) && (s == r.a3) && (r.res != RES_NW);
  endfunction

  // Stall decision for one source: only the youngest matching writer counts.
  function automatic logic src_stall(input logic [SB_AW-1:0] s,
                                     input logic [SB_TW-1:0] tuse,
                                     input sb_rec_t e, input sb_rec_t m,
                                     input sb_rec_t w);
    if (tuse == TUSE_NONE) return 1'b0;
    if (rec_match(s, e))   return e.tnew > tuse;
    if (rec_match(s, m))   return m.tnew > tuse;
    if (rec_match(s, w))   return w.tnew > tuse;
    return 1'b0;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// fwd_sel: combinational youngest-first forward select for one operand.
//   src        source register address being read
//   e_rec/m_rec/w_rec  writer records in E, M, W
//   reg_val    unforwarded value (GRF read or E operand register)
//   e_pc8, m_ao, m_md, m_pc8, w_wd  candidate forward values
//   val        selected operand value
//   hit        (HAZARD_STATS_EN only) operand came from a forward source
// USE_E=1 enables the E-stage PC+8 source (D-stage operands only).
module fwd_sel
  import fwd_pkg::*;
#(
  parameter int DW    = 32,
  parameter bit USE_E = 1'b0
) (
  input  logic [SB_AW-1:0] src,
  input  sb_rec_t          e_rec,
  input  sb_rec_t          m_rec,
  input  sb_rec_t          w_rec,
  input  logic [DW-1:0]    reg_val,
  input  logic [DW-1:0]    e_pc8,
  input  logic [DW-1:0]    m_ao,
  input  logic [DW-1:0]    m_md,
  input  logic [DW-1:0]    m_pc8,
  input  logic [DW-1:0]    w_wd,
  output logic [DW-1:0]    val
`ifdef HAZARD_STATS_EN
  ,
  output logic             hit
`endif
);

  fwd_sel_e sel;
  logic     m_ready;

  // An M writer forwards only once its result exists; DM is never
  // forwarded from M, so it falls through to older stages.
  assign m_ready = rec_match(src, m_rec) && (m_rec.tnew == '0);

  always_comb begin
    sel = SEL_REG;
    if (USE_E && rec_match(src, e_rec) && (e_rec.res == RES_PC)) sel = SEL_E_PC8;
    else if (m_ready && (m_rec.res == RES_ALU))                  sel = SEL_M_AO;
    else if (m_ready && (m_rec.res == RES_MD))                   sel = SEL_M_MD;
    else if (m_ready && (m_rec.res == RES_PC))                   sel = SEL_M_PC8;
    else if (rec_match(src, w_rec))                              sel = SEL_W_WD;
  end

  always_comb begin
    val = reg_val;
    case (sel)
      SEL_E_PC8: val = e_pc8;
      SEL_M_AO:  val = m_ao;
      SEL_M_MD:  val = m_md;
      SEL_M_PC8: val = m_pc8;
      SEL_W_WD:  val = w_wd;
      default:   val = reg_val;
    endcase
  end

`ifdef HAZARD_STATS_EN
  assign hit = (sel != SEL_REG);
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and hazard unit for a 5-stage MIPS pipeline.
// Owns an E/M/W writer scoreboard (a3, result class, Tnew countdown) and a
// mult/div busy counter; produces the D-stage stall, forwarded D operands
// (branch compare) and forwarded E operands.
// Ports:
//   clk, reset (synchronous, active low)
//   d_rs/d_rt, d_tuse_rs/d_tuse_rt   D sources and their Tuse (all-ones = unused)
//   d_a3, d_res, d_tnew              D destination, result class, Tnew
//   d_md_start, d_md_div, d_md_use   mult/div start, div select, hi/lo use
//   rf_rs/rf_rt, e_rs/e_rt           unforwarded D and E operand values
//   e_pc8, m_ao, m_pc8, m_md, w_wd   forward candidates
//   stall, d_fwd_rs/rt, e_fwd_rs/rt, md_busy
// Optional: define HAZARD_STATS_EN to add stat_stall_cyc and stat_fwd_cnt.
// AW/TW must equal fwd_pkg::SB_AW/SB_TW (records are sized by the package).
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = SB_AW,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int TW       = SB_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_a3,
  input  logic [2:0]    d_res,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  input  logic [DW-1:0] rf_rs,
  input  logic [DW-1:0] rf_rt,
  input  logic [DW-1:0] e_rs,
  input  logic [DW-1:0] e_rt,
  input  logic [DW-1:0] e_pc8,
  input  logic [DW-1:0] m_ao,
  input  logic [DW-1:0] m_pc8,
  input  logic [DW-1:0] m_md,
  input  logic [DW-1:0] w_wd,
  output logic          stall,
  output logic [DW-1:0] d_fwd_rs,
  output logic [DW-1:0] d_fwd_rt,
  output logic [DW-1:0] e_fwd_rs,
  output logic [DW-1:0] e_fwd_rt,
  output logic          md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]   stat_stall_cyc,
  output logic [31:0]   stat_fwd_cnt
`endif
);

  localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW     = $clog2(MD_MAX + 1);

  sb_rec_t       sb_e, sb_m, sb_w;
  sb_rec_t       d_rec, m_next;
  logic [AW-1:0] e_src_rs, e_src_rt;  // source addresses of the E instruction
  logic          e_md_start;          // E holds a mult/div start
  logic [CW-1:0] md_cnt;
  logic          d_enter;             // D instruction moves into E this edge

  assign d_rec  = '{a3: d_a3, res: d_res, tnew: d_tnew};
  assign m_next = '{a3: sb_e.a3, res: sb_e.res,
                    tnew: (sb_e.tnew == '0) ? sb_e.tnew : sb_e.tnew - SB_TW'(1)};

  assign md_busy = (md_cnt != '0) || e_md_start;
  assign stall   = src_stall(d_rs, d_tuse_rs, sb_e, sb_m, sb_w)
                || src_stall(d_rt, d_tuse_rt, sb_e, sb_m, sb_w)
                || (d_md_use && md_busy);
  assign d_enter = !stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sb_e       <= SB_BUBBLE;
      sb_m       <= SB_BUBBLE;
      sb_w       <= SB_BUBBLE;
      e_src_rs   <= '0;
      e_src_rt   <= '0;
      e_md_start <= 1'b0;
      md_cnt     <= '0;
    end else begin
      sb_w       <= sb_m;
      sb_m       <= m_next;
      sb_e       <= d_enter ? d_rec : SB_BUBBLE;
      e_src_rs   <= d_enter ? d_rs : '0;
      e_src_rt   <= d_enter ? d_rt : '0;
      e_md_start <= d_enter && d_md_start;
      if (d_enter && d_md_start)
        md_cnt <= d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - CW'(1);
    end
  end

`ifdef HAZARD_STATS_EN
  logic e_hit_rs, e_hit_rt, d_hit_rs, d_hit_rt;
`endif

  fwd_sel #(.DW(DW), .USE_E(1'b1)) u_d_rs (
    .src(d_rs), .e_rec(sb_e), .m_rec(sb_m), .w_rec(sb_w), .reg_val(rf_rs),
    .e_pc8(e_pc8), .m_ao(m_ao), .m_md(m_md), .m_pc8(m_pc8), .w_wd(w_wd),
    .val(d_fwd_rs)
`ifdef HAZARD_STATS_EN
    , .hit(d_hit_rs)
`endif
  );

  fwd_sel #(.DW(DW), .USE_E(1'b1)) u_d_rt (
    .src(d_rt), .e_rec(sb_e), .m_rec(sb_m), .w_rec(sb_w), .reg_val(rf_rt),
    .e_pc8(e_pc8), .m_ao(m_ao), .m_md(m_md), .m_pc8(m_pc8), .w_wd(w_wd),
    .val(d_fwd_rt)
`ifdef HAZARD_STATS_EN
    , .hit(d_hit_rt)
`endif
  );

  fwd_sel #(.DW(DW), .USE_E(1'b0)) u_e_rs (
    .src(e_src_rs), .e_rec(sb_e), .m_rec(sb_m), .w_rec(sb_w), .reg_val(e_rs),
    .e_pc8(e_pc8), .m_ao(m_ao), .m_md(m_md), .m_pc8(m_pc8), .w_wd(w_wd),
    .val(e_fwd_rs)
`ifdef HAZARD_STATS_EN
    , .hit(e_hit_rs)
`endif
  );

  fwd_sel #(.DW(DW), .USE_E(1'b0)) u_e_rt (
    .src(e_src_rt), .e_rec(sb_e), .m_rec(sb_m), .w_rec(sb_w), .reg_val(e_rt),
    .e_pc8(e_pc8), .m_ao(m_ao), .m_md(m_md), .m_pc8(m_pc8), .w_wd(w_wd),
    .val(e_fwd_rt)
`ifdef HAZARD_STATS_EN
    , .hit(e_hit_rt)
`endif
  );

`ifdef HAZARD_STATS_EN
  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_stall_cyc <= '0;
      stat_fwd_cnt   <= '0;
    end else begin
      if (stall)                 stat_stall_cyc <= stat_stall_cyc + 32'd1;
      if (e_hit_rs || e_hit_rt)  stat_fwd_cnt   <= stat_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed scenarios plus randomized
// stimulus checked against an array-based pipeline reference model.
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [4:0]    d_rs, d_rt, d_a3;
  logic [1:0]    d_tuse_rs, d_tuse_rt, d_tnew;
  logic [2:0]    d_res;
  logic          d_md_start, d_md_div, d_md_use;
  logic [DW-1:0] rf_rs, rf_rt, e_rs, e_rt, e_pc8, m_ao, m_pc8, m_md, w_wd;
  logic          stall, md_busy;
  logic [DW-1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stat_stall_cyc, stat_fwd_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_a3(d_a3), .d_res(d_res), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .e_rs(e_rs), .e_rt(e_rt),
    .e_pc8(e_pc8), .m_ao(m_ao), .m_pc8(m_pc8), .m_md(m_md), .w_wd(w_wd),
    .stall(stall), .d_fwd_rs(d_fwd_rs), .d_fwd_rt(d_fwd_rt),
    .e_fwd_rs(e_fwd_rs), .e_fwd_rt(e_fwd_rt), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cyc(stat_stall_cyc), .stat_fwd_cnt(stat_fwd_cnt)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_a3 = '0; d_res = RES_NW; d_tnew = '0;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [1:0] tu_rs,
                             input logic [4:0] rt, input logic [1:0] tu_rt,
                             input logic [4:0] a3, input logic [2:0] res,
                             input logic [1:0] tnew);
    drive_idle();
    d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
    d_a3 = a3; d_res = res; d_tnew = tnew;
  endtask

  task automatic randomize_data();
    rf_rs = $urandom; rf_rt = $urandom; e_rs = $urandom; e_rt = $urandom;
    e_pc8 = $urandom; m_ao = $urandom; m_pc8 = $urandom; m_md = $urandom;
    w_wd = $urandom;
  endtask

  // Leaves the bench at a negedge with reset released and one reset edge done.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Index 0 = E, 1 = M, 2 = W (youngest first).
  logic [4:0] ref_a3[3];
  logic [2:0] ref_res[3];
  int         ref_tnew[3];
  logic [4:0] ref_src_rs, ref_src_rt;
  bit         ref_emd;
  int         ref_cnt;

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      ref_a3[k] = '0; ref_res[k] = RES_NW; ref_tnew[k] = 0;
    end
    ref_src_rs = '0; ref_src_rt = '0; ref_emd = 1'b0; ref_cnt = 0;
  endtask

  function automatic bit ref_hit(input int k, input logic [4:0] s);
    return (s != 0) && (ref_a3[k] == s) && (ref_res[k] != RES_NW);
  endfunction

  function automatic bit ref_src_stall(input logic [4:0] s, input int tuse);
    if (tuse == 3) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (ref_hit(k, s)) return ref_tnew[k] > tuse;
    return 1'b0;
  endfunction

  function automatic bit ref_busy();
    return (ref_cnt != 0) || ref_emd;
  endfunction

  function automatic bit ref_stall();
    return ref_src_stall(d_rs, int'(d_tuse_rs)) || ref_src_stall(d_rt, int'(d_tuse_rt))
        || (d_md_use && ref_busy());
  endfunction

  function automatic logic [DW-1:0] ref_fwd(input logic [4:0] s, input bit d_side,
                                            input logic [DW-1:0] regv);
    if (d_side && ref_hit(0, s) && ref_res[0] == RES_PC) return e_pc8;
    if (ref_hit(1, s) && ref_tnew[1] == 0) begin
      if (ref_res[1] == RES_ALU) return m_ao;
      if (ref_res[1] == RES_MD)  return m_md;
      if (ref_res[1] == RES_PC)  return m_pc8;
    end
    if (ref_hit(2, s)) return w_wd;
    return regv;
  endfunction

  task automatic model_step(input bit st);
    if (!reset) begin
      model_clear();
    end else begin
      ref_a3[2] = ref_a3[1]; ref_res[2] = ref_res[1]; ref_tnew[2] = ref_tnew[1];
      ref_a3[1] = ref_a3[0]; ref_res[1] = ref_res[0];
      ref_tnew[1] = (ref_tnew[0] > 0) ? ref_tnew[0] - 1 : 0;
      if (st) begin
        ref_a3[0] = '0; ref_res[0] = RES_NW; ref_tnew[0] = 0;
        ref_src_rs = '0; ref_src_rt = '0;
      end else begin
        ref_a3[0] = d_a3; ref_res[0] = d_res; ref_tnew[0] = int'(d_tnew);
        ref_src_rs = d_rs; ref_src_rt = d_rt;
      end
      if (d_md_start && !st) ref_cnt = d_md_div ? 10 : 5;
      else if (ref_cnt > 0) ref_cnt--;
      ref_emd = d_md_start && !st;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    randomize_data();
    drive_instr(0, 3, 0, 3, 5'd1, RES_ALU, 2'd3);
    d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;
    do_reset();
    // A reader of $1 and an hi/lo user would stall if anything survived reset.
    drive_instr(5'd1, 2'd0, 5'd1, 2'd0, 0, RES_NW, 0);
    d_md_use = 1'b1;
    randomize_data();
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
    n_vec++; if (d_fwd_rs !== rf_rs) begin n_err++; $display("FAIL reset_d_fwd_rs: got %h want %h", d_fwd_rs, rf_rs); end
    n_vec++; if (d_fwd_rt !== rf_rt) begin n_err++; $display("FAIL reset_d_fwd_rt: got %h want %h", d_fwd_rt, rf_rt); end
    n_vec++; if (e_fwd_rs !== e_rs) begin n_err++; $display("FAIL reset_e_fwd_rs: got %h want %h", e_fwd_rs, e_rs); end
    n_vec++; if (e_fwd_rt !== e_rt) begin n_err++; $display("FAIL reset_e_fwd_rt: got %h want %h", e_fwd_rt, e_rt); end
  endtask

  task automatic test_branch_stall();
    do_reset();
    drive_instr(0, 3, 0, 3, 5'd1, RES_ALU, 2'd1);   // addu $1
    @(negedge clk);
    drive_instr(5'd1, 2'd0, 0, 2'd0, 0, RES_NW, 0); // beq $1,$0
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL branch_stall_e: got %b want 1", stall); end
    @(negedge clk);
    m_ao = 32'h0000_0005;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL branch_release: got %b want 0", stall); end
    n_vec++; if (d_fwd_rs !== 32'h5) begin n_err++; $display("FAIL branch_d_fwd_m_ao: got %h want 00000005", d_fwd_rs); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_instr(0, 3, 0, 3, 5'd2, RES_DM, 2'd2);       // lw $2
    @(negedge clk);
    drive_instr(5'd2, 2'd1, 0, 3, 5'd4, RES_ALU, 2'd1); // addu $4,$2
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall: got %b want 1", stall); end
    @(negedge clk);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_use_release: got %b want 0", stall); end
    n_vec++; if (d_fwd_rs !== rf_rs) begin n_err++; $display("FAIL load_dm_not_from_m: got %h want %h", d_fwd_rs, rf_rs); end
    @(negedge clk);
    drive_idle();
    w_wd = 32'h1234_5678;
    #1;
    n_vec++; if (e_fwd_rs !== 32'h1234_5678) begin n_err++; $display("FAIL load_e_fwd_w: got %h want 12345678", e_fwd_rs); end
  endtask

  task automatic test_m_over_w();
    do_reset();
    drive_instr(0, 3, 0, 3, 5'd3, RES_ALU, 2'd1);
    @(negedge clk);
    drive_instr(0, 3, 0, 3, 5'd3, RES_ALU, 2'd1);
    @(negedge clk);
    drive_instr(5'd3, 2'd1, 0, 3, 0, RES_NW, 0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL m_over_w_stall: got %b want 0", stall); end
    @(negedge clk);
    drive_idle();
    m_ao = 32'hA; w_wd = 32'hB;
    #1;
    n_vec++; if (e_fwd_rs !== 32'hA) begin n_err++; $display("FAIL m_over_w_e_fwd: got %h want 0000000a", e_fwd_rs); end
    n_vec++; if (e_fwd_rt !== e_rt) begin n_err++; $display("FAIL m_over_w_rt_reg: got %h want %h", e_fwd_rt, e_rt); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive_instr(0, 3, 0, 3, 5'd0, RES_ALU, 2'd1);  // writer of $0
    @(negedge clk);
    drive_instr(5'd0, 2'd0, 0, 3, 0, RES_NW, 0);   // reader of $0
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall: got %b want 0", stall); end
    @(negedge clk);
    drive_idle();
    m_ao = 32'hFFFF_FFFF; e_rs = 32'h0BAD_F00D;
    #1;
    n_vec++; if (e_fwd_rs !== 32'h0BAD_F00D) begin n_err++; $display("FAIL zero_e_fwd: got %h want 0badf00d", e_fwd_rs); end
  endtask

  task automatic test_md_busy();
    do_reset();
    drive_idle();
    d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;  // div
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL div_issue_stall: got %b want 0", stall); end
    @(negedge clk);
    drive_instr(0, 3, 0, 3, 5'd5, RES_MD, 2'd1);           // mflo $5
    d_md_use = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      #1;
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL div_stall cyc%0d: got %b want 1", k, stall); end
      n_vec++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL div_busy cyc%0d: got %b want 1", k, md_busy); end
      @(negedge clk);
    end
    #1;
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL div_done_busy: got %b want 0", md_busy); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL div_done_stall: got %b want 0", stall); end
    @(negedge clk);
    drive_idle();
    d_md_start = 1'b1; d_md_use = 1'b1;                      // mult
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mult_issue_stall: got %b want 0", stall); end
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL mult_busy: got %b want 1", md_busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    d_md_use = 1'b1;
    #1;
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL md_reset_busy: got %b want 0", md_busy); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL md_reset_stall: got %b want 0", stall); end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    n_vec++; if (stat_stall_cyc !== 32'd0) begin n_err++; $display("FAIL stats_reset_stall: got %0d want 0", stat_stall_cyc); end
    n_vec++; if (stat_fwd_cnt !== 32'd0) begin n_err++; $display("FAIL stats_reset_fwd: got %0d want 0", stat_fwd_cnt); end
    drive_instr(0, 3, 0, 3, 5'd1, RES_ALU, 2'd0);
    @(negedge clk);
    drive_instr(5'd1, 2'd1, 0, 3, 0, RES_NW, 0);
    @(negedge clk);  // E reader takes $1 from M
    @(negedge clk);  // E reader takes $1 from W
    drive_idle();
    @(negedge clk);
    d_md_start = 1'b1; d_md_use = 1'b1;
    @(negedge clk);
    drive_idle();
    d_md_use = 1'b1;
    repeat (3) @(negedge clk);
    drive_idle();
    #1;
    n_vec++; if (stat_stall_cyc !== 32'd3) begin n_err++; $display("FAIL stats_stall_cyc: got %0d want 3", stat_stall_cyc); end
    n_vec++; if (stat_fwd_cnt !== 32'd2) begin n_err++; $display("FAIL stats_fwd_cnt: got %0d want 2", stat_fwd_cnt); end
    do_reset();
    #1;
    n_vec++; if (stat_stall_cyc !== 32'd0) begin n_err++; $display("FAIL stats_clear_stall: got %0d want 0", stat_stall_cyc); end
    n_vec++; if (stat_fwd_cnt !== 32'd0) begin n_err++; $display("FAIL stats_clear_fwd: got %0d want 0", stat_fwd_cnt); end
  endtask
`endif

  task automatic test_random();
    bit exp_stall;
    logic [DW-1:0] exp_v;
    do_reset();
    model_clear();
    for (int cyc = 0; cyc < 300; cyc++) begin
      reset      = ($urandom_range(0, 59) != 0);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      d_a3       = 5'($urandom_range(0, 3));
      d_res      = 3'($urandom_range(0, 4));
      d_tnew     = 2'($urandom_range(0, 3));
      d_md_start = ($urandom_range(0, 9) == 0);
      d_md_div   = 1'($urandom_range(0, 1));
      d_md_use   = d_md_start || ($urandom_range(0, 5) == 0);
      randomize_data();
      #1;
      exp_stall = ref_stall();
      n_vec++; if (stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall cyc%0d: got %b want %b", cyc, stall, exp_stall); end
      n_vec++; if (md_busy !== ref_busy()) begin n_err++; $display("FAIL rnd_md_busy cyc%0d: got %b want %b", cyc, md_busy, ref_busy()); end
      exp_v = ref_fwd(d_rs, 1'b1, rf_rs);
      n_vec++; if (d_fwd_rs !== exp_v) begin n_err++; $display("FAIL rnd_d_fwd_rs cyc%0d: got %h want %h", cyc, d_fwd_rs, exp_v); end
      exp_v = ref_fwd(d_rt, 1'b1, rf_rt);
      n_vec++; if (d_fwd_rt !== exp_v) begin n_err++; $display("FAIL rnd_d_fwd_rt cyc%0d: got %h want %h", cyc, d_fwd_rt, exp_v); end
      exp_v = ref_fwd(ref_src_rs, 1'b0, e_rs);
      n_vec++; if (e_fwd_rs !== exp_v) begin n_err++; $display("FAIL rnd_e_fwd_rs cyc%0d: got %h want %h", cyc, e_fwd_rs, exp_v); end
      exp_v = ref_fwd(ref_src_rt, 1'b0, e_rt);
      n_vec++; if (e_fwd_rt !== exp_v) begin n_err++; $display("FAIL rnd_e_fwd_rt cyc%0d: got %h want %h", cyc, e_fwd_rt, exp_v); end
      model_step(exp_stall);
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    drive_idle();
    randomize_data();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_branch_stall();
    test_load_use();
    test_m_over_w();
    test_reg_zero();
    test_md_busy();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
